// File: rtl/stroke_line_drawer_if.sv
// Point-in / pixel-out bundle for the stroke line drawer.
// slave = the drawer itself, master = whatever feeds points and consumes pixels.
interface stroke_line_drawer_if;
    logic [10:0] point_x;
    logic [10:0] point_y;
    logic        point_valid;
    logic        pen_down;
    logic        point_ready;
    logic [10:0] x;
    logic [10:0] y;
    logic        pixel_write;
    logic        busy;

    modport slave (
        input  point_x, point_y, point_valid, pen_down,
        output point_ready, x, y, pixel_write, busy
    );

    modport master (
        output point_x, point_y, point_valid, pen_down,
        input  point_ready, x, y, pixel_write, busy
    );
endinterface

// File: rtl/stroke_line_drawer.sv
// Joins successive cursor points with Bresenham lines, one pixel per clock.
// Pen-up points only move the anchor; pen-down points draw from the anchor.
module stroke_line_drawer #(
    parameter int X_MAX = 639,
    parameter int Y_MAX = 479
) (
    input logic                  CLOCK_50,
    input logic                  reset_n,
    stroke_line_drawer_if.slave  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] DRAW  = 2'd2;

    localparam logic [10:0] XM = X_MAX[10:0];
    localparam logic [10:0] YM = Y_MAX[10:0];

    logic [1:0]         state;
    logic [10:0]        ax, ay;         // anchor (last accepted point)
    logic               anchor_valid;
    logic [10:0]        x0, y0;         // line start
    logic [10:0]        x1, y1;         // line end
    logic [10:0]        cx, cy;         // current pixel, doubles as the x/y output
    logic               pw;
    logic               sx, sy;         // 1 = step +1, 0 = step -1
    logic signed [12:0] dx, dy, err;

    logic               accept;
    logic [10:0]        nx, ny;
    logic signed [12:0] ddx, ddy, adx, ady;
    logic signed [13:0] e2;
    logic               step_x, step_y;
    logic signed [12:0] err_nx;

    assign accept = bus.point_valid && (state == IDLE);

    assign bus.point_ready = (state == IDLE);
    assign bus.busy        = (state != IDLE);
    assign bus.x           = cx;
    assign bus.y           = cy;
    assign bus.pixel_write = pw;

    // Clamp the incoming point and derive line setup terms and the per-pixel step.
    always_comb begin
        nx     = (bus.point_x > XM) ? XM : bus.point_x;
        ny     = (bus.point_y > YM) ? YM : bus.point_y;
        ddx    = $signed({2'b00, x1}) - $signed({2'b00, x0});
        ddy    = $signed({2'b00, y1}) - $signed({2'b00, y0});
        adx    = ddx[12] ? -ddx : ddx;
        ady    = ddy[12] ? -ddy : ddy;
        e2     = {err, 1'b0};
        step_x = (e2 >= $signed({dy[12], dy}));
        step_y = (e2 <= $signed({dx[12], dx}));
        err_nx = err + (step_x ? dy : 13'sd0) + (step_y ? dx : 13'sd0);
    end

    // Control FSM, anchor tracking and the Bresenham walk.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            ax           <= '0;
            ay           <= '0;
            anchor_valid <= 1'b0;
            x0           <= '0;
            y0           <= '0;
            x1           <= '0;
            y1           <= '0;
            cx           <= '0;
            cy           <= '0;
            pw           <= 1'b0;
            sx           <= 1'b0;
            sy           <= 1'b0;
            dx           <= '0;
            dy           <= '0;
            err          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    pw <= 1'b0;
                    if (accept) begin
                        ax           <= nx;
                        ay           <= ny;
                        anchor_valid <= 1'b1;
                        if (bus.pen_down) begin
                            // With no previous point the stroke starts where it ends.
                            x0    <= anchor_valid ? ax : nx;
                            y0    <= anchor_valid ? ay : ny;
                            x1    <= nx;
                            y1    <= ny;
                            state <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    dx    <= adx;
                    dy    <= -ady;
                    err   <= adx - ady;
                    sx    <= (x0 < x1);
                    sy    <= (y0 < y1);
                    cx    <= x0;
                    cy    <= y0;
                    pw    <= 1'b1;
                    state <= DRAW;
                end
                DRAW: begin
                    if (cx == x1 && cy == y1) begin
                        pw    <= 1'b0;
                        state <= IDLE;
                    end else begin
                        if (step_x) cx <= sx ? cx + 11'd1 : cx - 11'd1;
                        if (step_y) cy <= sy ? cy + 11'd1 : cy - 11'd1;
                        err <= err_nx;
                        pw  <= 1'b1;
                    end
                end
                default: begin
                    pw    <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
